// File: rtl/vector_sequencer_pkg.sv
// vector_sequencer shared types: FSM states, table entry, default widths.
// Entry field widths follow the default DUT widths below.
package vseq_pkg;

    localparam int VSEQ_DEPTH = 32;
    localparam int VSEQ_IN_W  = 3;
    localparam int VSEQ_OUT_W = 1;
    localparam int VSEQ_CNT_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        APPLY,
        CHECK,
        DONE
    } vseq_state_e;

    typedef struct packed {
        logic                  valid;
        logic [VSEQ_IN_W-1:0]  in;
        logic [VSEQ_OUT_W-1:0] exp;
    } vseq_entry_t;

endpackage

// File: rtl/vector_sequencer_if.sv
// vector_sequencer host bus: table load port, run control and status.
// master = host / bench, slave = vector_sequencer.
interface vector_sequencer_if
    import vseq_pkg::*;
#(
    parameter int DEPTH = VSEQ_DEPTH,
    parameter int IN_W  = VSEQ_IN_W,
    parameter int OUT_W = VSEQ_OUT_W,
    parameter int CNT_W = VSEQ_CNT_W
);
    localparam int AW = $clog2(DEPTH);

    logic                  load_en;
    logic [AW-1:0]         load_addr;
    logic [IN_W+OUT_W-1:0] load_data;
    logic                  start;
    logic                  busy;
    logic                  done;
    logic                  err_pulse;
    logic [CNT_W-1:0]      errors;
    logic [CNT_W-1:0]      vectornum;

    modport master (
        output load_en, load_addr, load_data, start,
        input  busy, done, err_pulse, errors, vectornum
    );

    modport slave (
        input  load_en, load_addr, load_data, start,
        output busy, done, err_pulse, errors, vectornum
    );

endinterface

// File: rtl/vector_sequencer_table.sv
// vseq_table: DEPTH-entry vector store with per-entry valid bits and
// a combinational read port. Valid bits clear on reset; data does not.
module vseq_table
    import vseq_pkg::*;
#(
    parameter int DEPTH = VSEQ_DEPTH,
    parameter int IN_W  = VSEQ_IN_W,
    parameter int OUT_W = VSEQ_OUT_W,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  wr_en,
    input  logic [AW-1:0]         wr_addr,
    input  logic [IN_W+OUT_W-1:0] wr_data,
    input  logic [AW-1:0]         rd_idx,
    output vseq_entry_t           rd_entry,
    output logic [DEPTH-1:0]      valid
);

    logic [DEPTH-1:0]      valid_q;
    logic [IN_W+OUT_W-1:0] data_q [DEPTH];

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            valid_q <= '0;
        end else if (wr_en) begin
            valid_q[wr_addr] <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) begin
            data_q[wr_addr] <= wr_data;
        end
    end

    assign rd_entry = {valid_q[rd_idx], data_q[rd_idx]};
    assign valid    = valid_q;

endmodule

// File: rtl/vector_sequencer.sv
// vector_sequencer: applies stored vectors to a combinational DUT and checks
// the response one cycle later. Option macro: VSEQ_STOP_ON_ERROR_EN.
module vector_sequencer
    import vseq_pkg::*;
#(
    parameter int DEPTH = VSEQ_DEPTH,
    parameter int IN_W  = VSEQ_IN_W,
    parameter int OUT_W = VSEQ_OUT_W,
    parameter int CNT_W = VSEQ_CNT_W
) (
    input  logic              clk,
    input  logic              reset,
    vector_sequencer_if.slave bus,
    output logic [IN_W-1:0]   dut_in,
    input  logic [OUT_W-1:0]  dut_out
`ifdef VSEQ_STOP_ON_ERROR_EN
    ,
    output logic [IN_W-1:0]   fail_in,
    output logic [OUT_W-1:0]  fail_out
`endif
);

    localparam int AW = $clog2(DEPTH);
    localparam int IW = AW + 1;

    vseq_state_e      state_q, state_d;
    logic [IW-1:0]    idx_q;
    logic [IW-1:0]    idx_inc;
    logic [OUT_W-1:0] exp_q;
    logic [CNT_W-1:0] errors_q;
    logic [CNT_W-1:0] vnum_q;
    logic             err_q;
    logic             busy;
    logic             wr_en;
    logic             go;
    logic             v0;
    logic             nxt_ok;
    logic             mismatch;
    logic [AW-1:0]    rd_idx;
    logic [DEPTH-1:0] valid;
    vseq_entry_t      rd;

    assign busy     = (state_q == APPLY) || (state_q == CHECK);
    assign wr_en    = bus.load_en & ~busy;
    assign go       = bus.start & ~busy;
    assign rd_idx   = (state_q == APPLY) ? idx_q[AW-1:0] : '0;
    // A same-cycle write to entry 0 must count as valid for the start decision.
    assign v0       = rd.valid | (wr_en && (bus.load_addr == '0));
    assign idx_inc  = idx_q + 1'b1;
    assign nxt_ok   = (idx_inc != IW'(DEPTH)) && valid[idx_inc[AW-1:0]];
    assign mismatch = (dut_out != exp_q);

    vseq_table #(
        .DEPTH (DEPTH),
        .IN_W  (IN_W),
        .OUT_W (OUT_W)
    ) u_table (
        .clk      (clk),
        .reset    (reset),
        .wr_en    (wr_en),
        .wr_addr  (bus.load_addr),
        .wr_data  (bus.load_data),
        .rd_idx   (rd_idx),
        .rd_entry (rd),
        .valid    (valid)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE, DONE: begin
                if (bus.start) begin
                    state_d = v0 ? APPLY : DONE;
                end
            end
            APPLY: state_d = CHECK;
            CHECK: begin
                state_d = nxt_ok ? APPLY : DONE;
`ifdef VSEQ_STOP_ON_ERROR_EN
                if (mismatch) begin
                    state_d = DONE;
                end
`endif
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            idx_q    <= '0;
            dut_in   <= '0;
            exp_q    <= '0;
            errors_q <= '0;
            vnum_q   <= '0;
            err_q    <= 1'b0;
        end else begin
            err_q <= 1'b0;
            if (go) begin
                idx_q    <= '0;
                errors_q <= '0;
                vnum_q   <= '0;
            end
            if (state_q == APPLY) begin
                dut_in <= rd.in;
                exp_q  <= rd.exp;
            end
            if (state_q == CHECK) begin
                idx_q  <= idx_inc;
                vnum_q <= vnum_q + 1'b1;
                if (mismatch) begin
                    err_q <= 1'b1;
                    if (~&errors_q) begin
                        errors_q <= errors_q + 1'b1;
                    end
                end
            end
        end
    end

`ifdef VSEQ_STOP_ON_ERROR_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            fail_in  <= '0;
            fail_out <= '0;
        end else if ((state_q == CHECK) && mismatch) begin
            fail_in  <= dut_in;
            fail_out <= dut_out;
        end
    end
`endif

    assign bus.busy      = busy;
    assign bus.done      = (state_q == DONE);
    assign bus.err_pulse = err_q;
    assign bus.errors    = errors_q;
    assign bus.vectornum = vnum_q;

endmodule

// File: tb/tb_vector_sequencer.sv
// Scoreboard bench for vector_sequencer driving a y = ~b~c | a~b DUT.
// Stimulus pushes expected err/done events; a negedge monitor checks them.
module tb_vector_sequencer;

    localparam int DEPTH = 32;
    localparam int IN_W  = 3;
    localparam int OUT_W = 1;
    localparam int CNT_W = 32;
    localparam int AW    = 5;
`ifdef VSEQ_STOP_ON_ERROR_EN
    localparam bit STOP = 1'b1;
`else
    localparam bit STOP = 1'b0;
`endif

    typedef struct {
        bit         is_done;
        int         vnum;
        int         errs;
        int         lat;
        logic [2:0] din;
        logic [2:0] fin;
        logic       fout;
    } rec_t;

    logic             clk = 1'b0;
    logic             reset = 1'b0;
    logic [IN_W-1:0]  dut_in;
    logic [OUT_W-1:0] dut_out;
`ifdef VSEQ_STOP_ON_ERROR_EN
    logic [IN_W-1:0]  fail_in;
    logic [OUT_W-1:0] fail_out;
`endif

    int   n_run = 0;
    int   n_fail = 0;
    int   cyc = 0;
    int   start_cyc = 0;
    rec_t sb[$];
    bit         m_valid [DEPTH];
    logic [2:0] m_in [DEPTH];
    logic       m_exp [DEPTH];
    logic [2:0] m_din = 3'd0;
    logic [2:0] m_fin = 3'd0;
    logic       m_fout = 1'b0;
    logic       done_prev = 1'b0;

    vector_sequencer_if #(
        .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) bus ();

    vector_sequencer #(
        .DEPTH(DEPTH), .IN_W(IN_W), .OUT_W(OUT_W), .CNT_W(CNT_W)
    ) dut (
        .clk     (clk),
        .reset   (reset),
        .bus     (bus),
        .dut_in  (dut_in),
        .dut_out (dut_out)
`ifdef VSEQ_STOP_ON_ERROR_EN
        ,
        .fail_in (fail_in),
        .fail_out(fail_out)
`endif
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic lx(input logic [2:0] v);
        return (~v[1] & ~v[0]) | (v[2] & ~v[1]);
    endfunction

    assign dut_out = lx(dut_in);

    function automatic void chk(input string name, input logic [63:0] act,
                                input logic [63:0] exp);
        n_run++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, want %0d", name, act, exp);
        end
    endfunction

    always @(negedge clk) begin
        rec_t r;
        if (!reset) begin
            done_prev = 1'b0;
        end else begin
            if (bus.err_pulse) begin
                if (sb.size() == 0) begin
                    chk("spurious_err_pulse", bus.err_pulse, 0);
                end else begin
                    r = sb.pop_front();
                    chk("err_event_kind", r.is_done, 0);
                    chk("err_vectornum", bus.vectornum, r.vnum);
                    chk("err_errors", bus.errors, r.errs);
                end
            end
            if (bus.done && !done_prev) begin
                if (sb.size() == 0) begin
                    chk("spurious_done", bus.done, 0);
                end else begin
                    r = sb.pop_front();
                    chk("done_event_kind", r.is_done, 1);
                    chk("done_vectornum", bus.vectornum, r.vnum);
                    chk("done_errors", bus.errors, r.errs);
                    chk("done_latency", cyc - start_cyc, r.lat);
                    chk("done_dut_in", dut_in, r.din);
`ifdef VSEQ_STOP_ON_ERROR_EN
                    chk("done_fail_in", fail_in, r.fin);
                    chk("done_fail_out", fail_out, r.fout);
`endif
                end
            end
            done_prev = bus.done;
        end
    end

    task automatic load(input int a, input logic [2:0] i, input logic e);
        @(negedge clk);
        bus.load_en   = 1'b1;
        bus.load_addr = a[AW-1:0];
        bus.load_data = {i, e};
        m_valid[a] = 1'b1;
        m_in[a]    = i;
        m_exp[a]   = e;
        @(negedge clk);
        bus.load_en = 1'b0;
    endtask

    // Pulses start (optionally with a same-cycle write) and queues the
    // expected events from the bench's own table copy.
    task automatic run(input bit wl, input int la, input logic [3:0] ld);
        rec_t r;
        int   v;
        int   e;
        @(negedge clk);
        if (wl) begin
            bus.load_en   = 1'b1;
            bus.load_addr = la[AW-1:0];
            bus.load_data = ld;
            m_valid[la] = 1'b1;
            m_in[la]    = ld[3:1];
            m_exp[la]   = ld[0];
        end
        bus.start = 1'b1;
        start_cyc = cyc + 1;
        v = 0;
        e = 0;
        for (int k = 0; k < DEPTH; k++) begin
            if (!m_valid[k]) break;
            v = k + 1;
            m_din = m_in[k];
            if (lx(m_in[k]) != m_exp[k]) begin
                e++;
                r = '{0, v, e, 0, 3'd0, 3'd0, 1'b0};
                sb.push_back(r);
                if (STOP) begin
                    m_fin  = m_in[k];
                    m_fout = lx(m_in[k]);
                    break;
                end
            end
        end
        r = '{1, v, e, 2 * v, m_din, m_fin, m_fout};
        sb.push_back(r);
        @(negedge clk);
        bus.start   = 1'b0;
        bus.load_en = 1'b0;
    endtask

    task automatic wait_sb(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 200) begin
            @(negedge clk);
            n++;
        end
        chk({name, "_timeout"}, sb.size(), 0);
    endtask

    task automatic reset_checks(input string tag);
        chk({tag, "_busy"}, bus.busy, 0);
        chk({tag, "_done"}, bus.done, 0);
        chk({tag, "_err_pulse"}, bus.err_pulse, 0);
        chk({tag, "_errors"}, bus.errors, 0);
        chk({tag, "_vectornum"}, bus.vectornum, 0);
        chk({tag, "_dut_in"}, dut_in, 0);
    endtask

    task automatic hard_reset();
        @(negedge clk);
        #1 reset = 1'b0;
        sb.delete();
        for (int k = 0; k < DEPTH; k++) m_valid[k] = 1'b0;
        m_din  = 3'd0;
        m_fin  = 3'd0;
        m_fout = 1'b0;
        #1 reset_checks("reset");
        @(negedge clk);
        reset = 1'b1;
    endtask

    initial begin
        bus.load_en   = 1'b0;
        bus.load_addr = '0;
        bus.load_data = '0;
        bus.start     = 1'b0;
        for (int k = 0; k < DEPTH; k++) m_valid[k] = 1'b0;
        repeat (2) @(negedge clk);
        reset_checks("por");
        reset = 1'b1;

        // empty table
        run(0, 0, 4'd0);
        wait_sb("empty");

        // all eight combinations, correct expectations
        for (int k = 0; k < 8; k++) load(k, k[2:0], lx(k[2:0]));
        run(0, 0, 4'd0);
        wait_sb("good8");

        // entry 3 expectation inverted
        load(3, 3'd3, ~lx(3'd3));
        run(0, 0, 4'd0);
        wait_sb("bad3");

        // abort three cycles into a five-vector run
        hard_reset();
        load(0, 3'd1, ~lx(3'd1));
        for (int k = 1; k < 5; k++) load(k, 3'(k + 1), lx(3'(k + 1)));
        run(0, 0, 4'd0);
        @(negedge clk);
        @(negedge clk);
        chk("abort_pre_dut_in", dut_in, 1);
        #1 reset = 1'b0;
        sb.delete();
        for (int k = 0; k < DEPTH; k++) m_valid[k] = 1'b0;
        m_din = 3'd0;
        #1 reset_checks("abort");
        @(negedge clk);
        reset = 1'b1;
        run(0, 0, 4'd0);
        wait_sb("post_abort_empty");

        // write and start in the same cycle
        run(1, 0, {3'b101, lx(3'b101)});
        wait_sb("load_start");

        // full table, then re-run from DONE
        for (int k = 0; k < DEPTH; k++) load(k, k[2:0], lx(k[2:0]));
        run(0, 0, 4'd0);
        wait_sb("full32");
        run(0, 0, 4'd0);
        chk("rerun_vectornum_clear", bus.vectornum, 0);
        chk("rerun_busy", bus.busy, 1);
        wait_sb("rerun32");

`ifdef VSEQ_STOP_ON_ERROR_EN
        hard_reset();
        for (int k = 0; k < 8; k++) begin
            if (k == 2) load(k, 3'd2, ~lx(3'd2));
            else load(k, k[2:0], lx(k[2:0]));
        end
        run(0, 0, 4'd0);
        wait_sb("stop_on_err");
`endif

        repeat (3) @(negedge clk);
        $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
        $finish;
    end

endmodule
